// File: rtl/cache_miss_ctrl_if.sv
// Single-port memory bus between the miss sequencer (master) and the memory side (slave).
interface cache_miss_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64
);
   logic                    mem_req;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [2*DATA_WIDTH-1:0] mem_wdata;
   logic                    mem_gnt;
   logic                    mem_rvalid;
   logic [2*DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer for the 2-way write-back bank: evicts a dirty victim, then refills the line in 2-word beats.
// Optional macro CACHE_MISS_CRITICAL_FIRST_EN starts the refill at the beat holding the requested word.
module cache_miss_ctrl #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned BANK_NUM   = 4
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           miss_cache_i,
   input  logic [ADDR_WIDTH-1:0]          addr_cache_i,
   input  logic                           set_cache_i,
   input  logic [$clog2(BANK_NUM)-1:0]    miss_offset_i,
   input  logic                           need_wb_i,
   input  logic [ADDR_WIDTH-1:0]          addr_wb_i,
   input  logic [BANK_NUM*DATA_WIDTH-1:0] data_wb_i,
   output logic                           busy_wb_o,
   output logic                           busy_rd_o,
   output logic [ADDR_WIDTH-1:0]          addr_rd_o,
   output logic [2*DATA_WIDTH-1:0]        data_rd_o,
   output logic                           wen_rd_o,
   output logic                           set_rd_o,
   output logic                           finish_rd_o,
   cache_miss_ctrl_if.master              mem
);

   localparam int unsigned BEATS      = BANK_NUM / 2;
   localparam int unsigned BEAT_W     = 2 * DATA_WIDTH;
   localparam int unsigned BEAT_BYTES = 2 * (DATA_WIDTH / 8);
   localparam int unsigned LINE_W     = BANK_NUM * DATA_WIDTH;
   localparam int unsigned OFF_W      = $clog2(BANK_NUM);
   localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WB      = 3'd1;
   localparam logic [2:0] S_RD_REQ  = 3'd2;
   localparam logic [2:0] S_RD_WAIT = 3'd3;
   localparam logic [2:0] S_FIN     = 3'd4;

   logic [2:0]            state_q,     state_d;
   logic [CNT_W-1:0]      beat_q,      beat_d;
   logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
   logic [ADDR_WIDTH-1:0] wb_addr_q,   wb_addr_d;
   logic [LINE_W-1:0]     wb_data_q,   wb_data_d;
   logic                  way_q,       way_d;
   logic [OFF_W-1:0]      off_q,       off_d;

   logic [CNT_W-1:0]      order_c;
   logic                  last_c;
   logic [ADDR_WIDTH-1:0] rd_addr_c;
   logic [ADDR_WIDTH-1:0] wb_addr_c;
   logic [BEAT_W-1:0]     wb_beat_c;

   logic                  mem_req_c;
   logic                  mem_we_c;
   logic [ADDR_WIDTH-1:0] mem_addr_c;
   logic [BEAT_W-1:0]     mem_wdata_c;
   logic                  wen_rd_c;
   logic [BEAT_W-1:0]     data_rd_c;
   logic [ADDR_WIDTH-1:0] addr_rd_c;

   // Refill beat order: wrap from the beat holding the requested word, or plain ascending
`ifdef CACHE_MISS_CRITICAL_FIRST_EN
   assign order_c = CNT_W'((32'(off_q >> 1) + 32'(beat_q)) % BEATS);
`else
   logic unused_off;
   assign order_c    = beat_q;
   assign unused_off = ^off_q;
`endif

   assign last_c    = (beat_q == CNT_W'(BEATS - 1));
   assign rd_addr_c = line_addr_q + ADDR_WIDTH'(32'(order_c) * BEAT_BYTES);
   assign wb_addr_c = wb_addr_q + ADDR_WIDTH'(32'(beat_q) * BEAT_BYTES);
   assign wb_beat_c = BEAT_W'(wb_data_q >> (32'(beat_q) * BEAT_W));

   // Next-state, latch updates and bus/refill drive
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      line_addr_d = line_addr_q;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      way_d       = way_q;
      off_d       = off_q;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      wen_rd_c    = 1'b0;
      data_rd_c   = '0;
      addr_rd_c   = line_addr_q;

      case (state_q)
         S_IDLE: begin
            if (miss_cache_i) begin
               line_addr_d = addr_cache_i;
               way_d       = set_cache_i;
               wb_addr_d   = addr_wb_i;
               wb_data_d   = data_wb_i;
               off_d       = miss_offset_i;
               beat_d      = '0;
               state_d     = need_wb_i ? S_WB : S_RD_REQ;
            end
         end
         S_WB: begin
            mem_req_c   = 1'b1;
            mem_we_c    = 1'b1;
            mem_addr_c  = wb_addr_c;
            mem_wdata_c = wb_beat_c;
            if (mem.mem_gnt) begin
               if (last_c) begin
                  beat_d  = '0;
                  state_d = S_RD_REQ;
               end else begin
                  beat_d = beat_q + CNT_W'(1);
               end
            end
         end
         S_RD_REQ: begin
            mem_req_c  = 1'b1;
            mem_addr_c = rd_addr_c;
            if (mem.mem_gnt) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (mem.mem_rvalid) begin
               wen_rd_c  = 1'b1;
               data_rd_c = mem.mem_rdata;
               addr_rd_c = rd_addr_c;
               if (last_c) begin
                  state_d = S_FIN;
               end else begin
                  beat_d  = beat_q + CNT_W'(1);
                  state_d = S_RD_REQ;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         line_addr_q <= '0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         way_q       <= 1'b0;
         off_q       <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         line_addr_q <= line_addr_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         way_q       <= way_d;
         off_q       <= off_d;
      end
   end

   // Busy flags decode only the state register so the bank sees no path from miss_cache
   assign busy_wb_o   = (state_q == S_WB);
   assign busy_rd_o   = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) || (state_q == S_FIN);
   assign finish_rd_o = (state_q == S_FIN);
   assign set_rd_o    = way_q;
   assign wen_rd_o    = wen_rd_c;
   assign data_rd_o   = data_rd_c;
   assign addr_rd_o   = addr_rd_c;

   assign mem.mem_req   = mem_req_c;
   assign mem.mem_we    = mem_we_c;
   assign mem.mem_addr  = mem_addr_c;
   assign mem.mem_wdata = mem_wdata_c;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: a line-level miss model feeds expected bus and refill queues,
// a memory responder with random latency drives the bus, and a monitor pops and compares.
module tb_cache_miss_ctrl;

   localparam int unsigned AW    = 64;
   localparam int unsigned DW    = 64;
   localparam int unsigned BANKS = 4;
   localparam int unsigned BEATS = BANKS / 2;

   typedef struct packed {
      logic           we;
      logic [AW-1:0]  addr;
      logic [127:0]   wdata;
   } mem_t;

   typedef struct packed {
      logic [AW-1:0]  addr;
      logic [127:0]   data;
      logic           way;
   } ref_t;

   logic                  clk;
   logic                  rstn;
   logic                  miss_cache;
   logic [AW-1:0]         addr_cache;
   logic                  set_cache;
   logic [1:0]            miss_offset;
   logic                  need_wb;
   logic [AW-1:0]         addr_wb;
   logic [BANKS*DW-1:0]   data_wb;
   logic                  busy_wb, busy_rd, wen_rd, set_rd, finish_rd;
   logic [AW-1:0]         addr_rd;
   logic [2*DW-1:0]       data_rd;

   cache_miss_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

   cache_miss_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BANKS)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .miss_cache_i  (miss_cache),
      .addr_cache_i  (addr_cache),
      .set_cache_i   (set_cache),
      .miss_offset_i (miss_offset),
      .need_wb_i     (need_wb),
      .addr_wb_i     (addr_wb),
      .data_wb_i     (data_wb),
      .busy_wb_o     (busy_wb),
      .busy_rd_o     (busy_rd),
      .addr_rd_o     (addr_rd),
      .data_rd_o     (data_rd),
      .wen_rd_o      (wen_rd),
      .set_rd_o      (set_rd),
      .finish_rd_o   (finish_rd),
      .mem           (mem_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   mem_t exp_mem[$];
   ref_t exp_ref[$];
   int   exp_fin[$];

   // memory responder knobs
   int   force_wait = -1;
   int   gmax = 0;
   int   force_rd = -1;
   int   rmax = 0;
   bit   spur_en = 0;
   bit   pending = 0;

   // monitor state
   bit   mon_en = 0;
   int   done_cnt = 0;
   int   rel = 0;
   int   wen_rel[$];
   logic [AW-1:0] rd_addrs[$];
   int   fin_rel = -1;
   int   wb_cnt = 0;

   function automatic logic [127:0] memfn(input logic [AW-1:0] a);
      return {~a, a ^ 64'h0123_4567_89AB_CDEF};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event with no expectation (t=%0t)", nm, $time);
   endtask

   // Memory side: grant after a chosen wait, return read data after a chosen delay, optional stray rvalid
   initial begin
      int wcnt = 0;
      int rd_cnt = 0;
      bit armed = 0;
      logic [AW-1:0] pend_addr = '0;
      mem_if.mem_gnt    = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = '0;
      forever begin
         @(negedge clk);
         #1;
         mem_if.mem_gnt    = 1'b0;
         mem_if.mem_rvalid = 1'b0;
         mem_if.mem_rdata  = '0;
         if (!rstn) begin
            pending = 0;
            armed   = 0;
         end else if (pending) begin
            if (rd_cnt == 0) begin
               mem_if.mem_rvalid = 1'b1;
               mem_if.mem_rdata  = memfn(pend_addr);
               pending = 0;
            end else begin
               rd_cnt--;
            end
         end else begin
            if (spur_en && $urandom_range(0, 1) == 1) begin
               mem_if.mem_rvalid = 1'b1;
               mem_if.mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (mem_if.mem_req) begin
               if (!armed) begin
                  armed = 1;
                  wcnt  = (force_wait >= 0) ? force_wait : int'($urandom_range(0, gmax));
               end
               if (wcnt == 0) begin
                  mem_if.mem_gnt = 1'b1;
                  armed = 0;
                  if (!mem_if.mem_we) begin
                     pending   = 1;
                     pend_addr = mem_if.mem_addr;
                     rd_cnt    = (force_rd >= 0) ? force_rd : int'($urandom_range(0, rmax));
                  end
               end else begin
                  wcnt--;
               end
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT shows a handshake, a refill write or a finish
   initial begin
      bit held = 0;
      bit prev_fin = 0;
      mem_t hv;
      mem_t e;
      ref_t r;
      forever begin
         @(negedge clk);
         #2;
         if (miss_cache) begin
            rel = 0;
            wen_rel.delete();
            rd_addrs.delete();
            fin_rel = -1;
            wb_cnt = 0;
         end else begin
            rel++;
         end
         if (!mon_en) begin
            held = 0;
            prev_fin = 0;
         end else begin
            if (held) begin
               check("hold_req", mem_if.mem_req, 1'b1);
               check("hold_we", mem_if.mem_we, hv.we);
               check("hold_addr", mem_if.mem_addr, hv.addr);
               check("hold_wdata", mem_if.mem_wdata, hv.wdata);
            end
            held = mem_if.mem_req && !mem_if.mem_gnt;
            hv   = '{we: mem_if.mem_we, addr: mem_if.mem_addr, wdata: mem_if.mem_wdata};

            if (mem_if.mem_req && mem_if.mem_gnt) begin
               if (exp_mem.size() == 0) fail_now("mem_unexpected");
               else begin
                  e = exp_mem.pop_front();
                  check("mem_we", mem_if.mem_we, e.we);
                  check("mem_addr", mem_if.mem_addr, e.addr);
                  if (e.we) check("mem_wdata", mem_if.mem_wdata, e.wdata);
               end
            end

            if (wen_rd) begin
               wen_rel.push_back(rel);
               rd_addrs.push_back(addr_rd);
               if (exp_ref.size() == 0) fail_now("wen_unexpected");
               else begin
                  r = exp_ref.pop_front();
                  check("addr_rd", addr_rd, r.addr);
                  check("data_rd", data_rd, r.data);
                  check("set_rd", set_rd, r.way);
               end
            end

            if (busy_wb) wb_cnt++;
            if (busy_wb && busy_rd) fail_now("busy_both");

            if (prev_fin) check("busy_after_fin", {busy_wb, busy_rd}, 2'b00);
            prev_fin = finish_rd;
            if (finish_rd) begin
               fin_rel = rel;
               if (exp_fin.size() == 0) fail_now("fin_unexpected");
               else begin
                  void'(exp_fin.pop_front());
                  check("fin_mem_left", exp_mem.size(), 0);
                  check("fin_ref_left", exp_ref.size(), 0);
               end
               done_cnt++;
            end
         end
      end
   end

   // Line-level model: eviction beats ascending, refill beats in the configured order
   task automatic do_miss(input logic [AW-1:0] la, input logic way, input logic [1:0] off,
                          input logic nwb, input logic [AW-1:0] wa, input logic [BANKS*DW-1:0] wd);
      int o;
      logic [AW-1:0] a;
      @(negedge clk);
      miss_cache  = 1'b1;
      addr_cache  = la;
      set_cache   = way;
      miss_offset = off;
      need_wb     = nwb;
      addr_wb     = wa;
      data_wb     = wd;
      if (nwb) begin
         for (int b = 0; b < BEATS; b++)
            exp_mem.push_back('{we: 1'b1, addr: wa + AW'(b * 16), wdata: wd[b*128 +: 128]});
      end
      for (int b = 0; b < BEATS; b++) begin
`ifdef CACHE_MISS_CRITICAL_FIRST_EN
         o = (int'(off) / 2 + b) % BEATS;
`else
         o = b;
`endif
         a = la + AW'(o * 16);
         exp_mem.push_back('{we: 1'b0, addr: a, wdata: '0});
         exp_ref.push_back('{addr: a, data: memfn(a), way: way});
      end
      exp_fin.push_back(1);
      @(negedge clk);
      miss_cache = 1'b0;
      addr_cache = {$urandom, $urandom};
      data_wb    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_done();
      int start;
      int k;
      start = done_cnt;
      k = 0;
      while (done_cnt == start && k < 300) begin
         @(negedge clk);
         #3;
         k++;
      end
      check("done_timeout", done_cnt != start, 1'b1);
   endtask

   task automatic check_all_zero(input string nm);
      check(nm, |{busy_wb, busy_rd, addr_rd, data_rd, wen_rd, set_rd, finish_rd,
                  mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BANKS*DW-1:0] wd;
      int k;
      rstn = 1'b0;
      miss_cache = 1'b0;
      addr_cache = '0;
      set_cache = 1'b0;
      miss_offset = '0;
      need_wb = 1'b0;
      addr_wb = '0;
      data_wb = '0;
      repeat (3) @(negedge clk);
      #2;
      check_all_zero("reset_outputs");
      rstn = 1'b1;
      mon_en = 1;
      @(negedge clk);
      #2;
      check_all_zero("idle_outputs");

      // clean miss, zero-wait memory, way 1
      force_wait = 0; force_rd = 0;
      do_miss(64'h1000, 1'b1, 2'd0, 1'b0, 64'h0, '0);
      wait_done();
      check("clean_wen_cnt", wen_rel.size(), BEATS);
      check("clean_wen0_cyc", wen_rel[0], 2);
      check("clean_wen1_cyc", wen_rel[1], 4);
      check("clean_fin_cyc", fin_rel, 5);
      check("clean_rd0_addr", rd_addrs[0], 64'h1000);
      check("clean_rd1_addr", rd_addrs[1], 64'h1010);

      // dirty miss: eviction of words A..D precedes the refill
      wd = {64'hD, 64'hC, 64'hB, 64'hA};
      do_miss(64'h1000, 1'b0, 2'd0, 1'b1, 64'h2000, wd);
      wait_done();
      check("dirty_wb_cycles", wb_cnt, 2);
      check("dirty_wen0_cyc", wen_rel[0], 4);
      check("dirty_fin_cyc", fin_rel, 7);

      // grant withheld three cycles on every request
      force_wait = 3;
      do_miss(64'h3000, 1'b1, 2'd0, 1'b1, 64'h4000, wd);
      wait_done();
      check("stall_wb_cycles", wb_cnt, 8);
      check("stall_wen_cnt", wen_rel.size(), BEATS);
      force_wait = 0;

      // requested word 3 lives in the upper beat
      do_miss(64'h1000, 1'b0, 2'd3, 1'b0, 64'h0, '0);
      wait_done();
`ifdef CACHE_MISS_CRITICAL_FIRST_EN
      check("crit_rd0_addr", rd_addrs[0], 64'h1010);
      check("crit_rd1_addr", rd_addrs[1], 64'h1000);
`else
      check("crit_rd0_addr", rd_addrs[0], 64'h1000);
      check("crit_rd1_addr", rd_addrs[1], 64'h1010);
`endif

      // reset while waiting for read data
      force_rd = 6;
      do_miss(64'h5000, 1'b1, 2'd0, 1'b0, 64'h0, '0);
      k = 0;
      while (!pending && k < 50) begin
         @(negedge clk);
         #3;
         k++;
      end
      check("reach_rd_wait", pending, 1'b1);
      @(negedge clk);
      mon_en = 0;
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      #2;
      check_all_zero("rst_mid_outputs");
      exp_mem.delete();
      exp_ref.delete();
      exp_fin.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #2;
         check("rst_no_finish", {finish_rd, busy_wb, busy_rd, wen_rd}, 4'b0000);
      end
      mon_en = 1;
      force_rd = 0;
      do_miss(64'h6000, 1'b0, 2'd1, 1'b0, 64'h0, '0);
      wait_done();
      check("post_rst_wen_cnt", wen_rel.size(), BEATS);

      // stray rvalid while idle and while evicting
      spur_en = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #3;
         check("spur_idle", {busy_wb, busy_rd, wen_rd, mem_if.mem_req}, 4'b0000);
      end
      force_wait = 2;
      do_miss(64'h7000, 1'b1, 2'd2, 1'b1, 64'h8000, wd);
      wait_done();
      check("spur_wb_cycles", wb_cnt, 6);
      force_wait = -1;

      // randomized misses with random latencies and stray rvalid
      gmax = 3; rmax = 3; force_rd = -1;
      for (int i = 0; i < 25; i++) begin
         wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         do_miss({$urandom, $urandom} & ~64'h1F, 1'($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom), {$urandom, $urandom} & ~64'h1F, wd);
         wait_done();
      end
      spur_en = 0;
      repeat (3) @(negedge clk);
      #3;
      check("drain_mem", exp_mem.size(), 0);
      check("drain_ref", exp_ref.size(), 0);
      check("drain_fin", exp_fin.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Miss sequencer for the 2-way write-back cache bank. It sits between the bank's miss/writeback/refill ports and a single-port memory bus. On a bank miss it latches the victim line and evicts it if it is dirty. It then fetches the new line in two-word beats, drives the bank's refill write port, and signals completion. It is the only block allowed to assert `busy_wb` and `busy_rd` toward the bank.

## Interface
- `ADDR_WIDTH`, 64, byte address width.
- `DATA_WIDTH`, 64, word width.
- `BANK_NUM`, 4, words per line; must be even and ≥2. `BEATS` = `BANK_NUM`/2.
- `clk` input 1: clock.
- `rstn` input 1: reset, synchronous, active-low.
- `miss_cache` input 1: bank miss accepted this cycle.
- `addr_cache` input `ADDR_WIDTH`: line-aligned miss address.
- `set_cache` input 1: victim way.
- `miss_offset` input clog2(`BANK_NUM`): requested word index within the line.
- `need_wb` input 1: victim is dirty.
- `addr_wb` input `ADDR_WIDTH`: victim line address.
- `data_wb` input `BANK_NUM`·`DATA_WIDTH`: victim line data.
- `busy_wb` output 1: writeback in progress.
- `busy_rd` output 1: refill in progress.
- `addr_rd` output `ADDR_WIDTH`: address of the refill beat.
- `data_rd` output 2·`DATA_WIDTH`: refill beat data, low word = even word.
- `wen_rd` output 1: refill beat write strobe.
- `set_rd` output 1: refill way.
- `finish_rd` output 1: line complete, one-cycle pulse.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = write, 0 = read.
- `mem_addr` output `ADDR_WIDTH`: beat address.
- `mem_wdata` output 2·`DATA_WIDTH`: write beat data.
- `mem_gnt` input 1: request accepted this cycle.
- `mem_rvalid` input 1: read data valid.
- `mem_rdata` input 2·`DATA_WIDTH`: read beat data.

## Operation
- States: IDLE, WB, RD_REQ, RD_WAIT, FIN.
- IDLE + `miss_cache` latches the following:
  - `addr_cache`, `set_cache`, `addr_wb`, `data_wb`, `miss_offset`.
  - Beat counter reset to 0.
  - Next state is WB if `need_wb`, else RD_REQ.
  - Capture is mandatory: the bank rewrites the tag and dirty bits on that edge.
- WB:
  - `mem_req`=1, `mem_we`=1.
  - `mem_addr` = wb_addr + beat·2·`BYTE_NUM`.
  - `mem_wdata` = latched data beat slice [beat·2·`DATA_WIDTH` +: 2·`DATA_WIDTH`].
  - On `mem_gnt` the beat counter increments; the last beat's `mem_gnt` goes to RD_REQ with the counter cleared.
- RD_REQ:
  - `mem_req`=1, `mem_we`=0.
  - `mem_addr` = line_addr + order(beat)·2·`BYTE_NUM`.
  - `mem_gnt` goes to RD_WAIT.
- RD_WAIT:
  - `mem_req`=0.
  - `mem_rvalid` drives `wen_rd`=1, `data_rd`=`mem_rdata`, `addr_rd`=that beat's address (combinational), and `set_rd`=latched way.
  - On `mem_rvalid`, go to FIN if this was the last beat; otherwise increment the counter and go to RD_REQ.
- FIN: `finish_rd`=1 for one cycle, then IDLE.
- `busy_wb` = (state==WB); `busy_rd` ∈ {RD_REQ, RD_WAIT, FIN}. Both are decoded from the state register only, with no path from `miss_cache`.
- `set_rd` and `addr_rd` hold the latched values outside RD_WAIT; `wen_rd`=0 outside RD_WAIT.
- One outstanding memory transaction at most. `mem_rvalid` outside RD_WAIT is ignored.
- `miss_cache` outside IDLE is ignored; it cannot occur while busy.

## Timing
- Reset values:
  - Outputs: all 0.
  - State: IDLE.
  - Latches and counter: 0.
- Reset mid-operation aborts to IDLE on that edge; no `finish_rd` is issued. The bus owner resets the memory side concurrently.
- `mem_req`, `mem_addr` and `mem_wdata` are held stable until `mem_gnt`. `mem_gnt` may arrive in the same cycle as `mem_req`.
- Cycle 0 is the `miss_cache` cycle. `busy_*` is high from cycle 1 until the FIN cycle inclusive, and is low on the cycle after FIN.
- Clean miss with zero-wait grant and `rvalid` one cycle after grant (`BANK_NUM`=4):
  - `wen_rd` in cycles 2 and 4.
  - `finish_rd` in cycle 5.
  - IDLE in cycle 6.
- A dirty miss adds `BEATS` cycles before the first read.

## Configuration
- `CACHE_MISS_CRITICAL_FIRST_EN` defined:
  - order(beat) = (`miss_offset`[top:1] + beat) mod `BEATS`.
  - The refill starts with the beat containing the requested word and wraps around.
- Undefined: order(beat) = beat, and `miss_offset` is ignored. The writeback order is always ascending.

## Test plan
- Clean miss, `addr_cache`=0x1000, way 1, zero-wait memory:
  - Reads at 0x1000 and 0x1010.
  - `wen_rd` with `set_rd`=1 in cycles 2 and 4.
  - `finish_rd` in cycle 5; busy is low in cycle 6.
- Dirty miss, `addr_wb`=0x2000, `data_wb` words 0..3 = 0xA..0xD:
  - Writes to 0x2000 with {0xB,0xA} and to 0x2010 with {0xD,0xC}, then the refill.
  - `busy_wb` is high exactly 2 cycles.
- `mem_gnt` withheld 3 cycles in WB and in RD_REQ: `mem_req`, `mem_addr` and `mem_wdata` stay stable, with no extra beats.
- With the macro and `miss_offset`=3: the read order is 0x1010 then 0x1000, and `addr_rd` matches each beat.
- `rstn` low during RD_WAIT: all outputs are 0 next cycle, there is no `finish_rd`, and a new `miss_cache` is accepted normally.
- Spurious `mem_rvalid` in IDLE and WB: no `wen_rd`, and the state is unchanged.
